// File: rtl/mac_unit_seq_pkg.sv
// mac_unit_seq_pkg: FSM state encoding and parameter sanity check shared by the MAC unit
package mac_unit_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
    function automatic bit widths_ok(int data_w, int acc_w, int len);
        return acc_w >= 2 * data_w && len >= 1;
    endfunction
endpackage

// File: rtl/mac_datapath.sv
// mac_datapath: combinational acc + a*b with overflow flag and clamp/wrap; ports acc,a,b in, sum,ovf out
module mac_datapath #(
    parameter int DATA_W   = 2,
    parameter int ACC_W    = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    logic              sa, sb;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W:0]    prod_x, acc_x, total;
    logic [ACC_W-1:0]  sat_val;
    assign sa      = SIGNED != 0 && a[DATA_W-1];
    assign sb      = SIGNED != 0 && b[DATA_W-1];
    assign prod    = {{DATA_W{sa}}, a} * {{DATA_W{sb}}, b};
    assign prod_x  = {{(ACC_W+1-2*DATA_W){SIGNED != 0 && prod[2*DATA_W-1]}}, prod};
    assign acc_x   = {SIGNED != 0 && acc[ACC_W-1], acc};
    assign total   = acc_x + prod_x;
    assign ovf     = SIGNED != 0 ? total[ACC_W] ^ total[ACC_W-1] : total[ACC_W];
    assign sat_val = SIGNED != 0 ? {total[ACC_W], {(ACC_W-1){~total[ACC_W]}}} : '1;
    assign sum     = ovf && SATURATE != 0 ? sat_val : total[ACC_W-1:0];
endmodule

// File: rtl/mac_unit_seq.sv
// mac_unit_seq: sequential MAC over LEN handshaked a/b pairs; start/acc_init in, acc_out/out_valid/busy/overflow out
module mac_unit_seq
    import mac_unit_seq_pkg::*;
#(
    parameter int DATA_W   = 2,
    parameter int ACC_W    = 8,
    parameter int LEN      = 4,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ACC_W-1:0]  acc_init,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overflow
);
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
    if (!widths_ok(DATA_W, ACC_W, LEN)) begin : g_bad_params
        $error("mac_unit_seq: need ACC_W >= 2*DATA_W and LEN >= 1");
    end
    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [ACC_W-1:0] acc_nx, dp_sum;
    logic             ovf_nx, dp_ovf, accept;
    mac_datapath #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED), .SATURATE(SATURATE)) u_dp (
        .acc(acc_out),
        .a  (a),
        .b  (b),
        .sum(dp_sum),
        .ovf(dp_ovf)
    );
    assign in_ready  = state == ACCUM;
    assign busy      = state == ACCUM;
    assign out_valid = state == DONE;
    // start wins over a concurrent accept, so an aborting cycle drops its a/b pair
    assign accept    = in_valid && in_ready && !start;
    always_comb begin
        state_nx = state;
        count_nx = count;
        acc_nx   = acc_out;
        ovf_nx   = overflow;
        if (start) begin
            state_nx = ACCUM;
            count_nx = '0;
            acc_nx   = acc_init;
            ovf_nx   = 1'b0;
        end else if (state == DONE) begin
            state_nx = IDLE;
        end else if (accept) begin
            state_nx = count == LAST ? DONE : ACCUM;
            count_nx = count + 1'b1;
            acc_nx   = dp_sum;
            ovf_nx   = overflow | dp_ovf;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            acc_out  <= acc_nx;
            overflow <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_mac_unit_seq.sv
// tb_mac_unit_seq: directed plan plus randomized runs against a transaction-level MAC model
module tb_mac_unit_seq;
    localparam int DW = 2, AW = 8, LEN = 4, NI = 4;
    logic clk = 1'b0;
    logic reset, start, in_valid;
    logic [AW-1:0] acc_init;
    logic [DW-1:0] a, b;
    logic [AW-1:0] acc_o [NI];
    logic rdy_o [NI], vld_o [NI], busy_o [NI], flg_o [NI];
    int n_tests = 0, n_fail = 0;
    int m_acc [NI];
    bit m_ovf [NI];
    bit m_sgn [NI] = '{0, 0, 1, 0};
    bit m_sat [NI] = '{1, 0, 1, 1};
    int m_cnt;
    bit one_act;

    always #5 clk = ~clk;

    mac_unit_seq #(.DATA_W(DW), .ACC_W(AW), .LEN(LEN), .SIGNED(0), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .start(start), .acc_init(acc_init), .in_valid(in_valid),
        .in_ready(rdy_o[0]), .a(a), .b(b), .acc_out(acc_o[0]), .out_valid(vld_o[0]),
        .busy(busy_o[0]), .overflow(flg_o[0]));
    mac_unit_seq #(.DATA_W(DW), .ACC_W(AW), .LEN(LEN), .SIGNED(0), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .acc_init(acc_init), .in_valid(in_valid),
        .in_ready(rdy_o[1]), .a(a), .b(b), .acc_out(acc_o[1]), .out_valid(vld_o[1]),
        .busy(busy_o[1]), .overflow(flg_o[1]));
    mac_unit_seq #(.DATA_W(DW), .ACC_W(AW), .LEN(LEN), .SIGNED(1), .SATURATE(1)) u_sgn (
        .clk(clk), .reset(reset), .start(start), .acc_init(acc_init), .in_valid(in_valid),
        .in_ready(rdy_o[2]), .a(a), .b(b), .acc_out(acc_o[2]), .out_valid(vld_o[2]),
        .busy(busy_o[2]), .overflow(flg_o[2]));
    mac_unit_seq #(.DATA_W(DW), .ACC_W(AW), .LEN(1), .SIGNED(0), .SATURATE(1)) u_one (
        .clk(clk), .reset(reset), .start(start), .acc_init(acc_init), .in_valid(in_valid),
        .in_ready(rdy_o[3]), .a(a), .b(b), .acc_out(acc_o[3]), .out_valid(vld_o[3]),
        .busy(busy_o[3]), .overflow(flg_o[3]));

    function automatic int val(int bits, int w, bit sgn);
        return (sgn && bits >= (1 << (w - 1))) ? bits - (1 << w) : bits;
    endfunction

    // acc + x*y with range check, then clamp or modulo-2^AW wrap
    function automatic int step(int acc, int x, int y, bit sgn, bit sat, output bit ov);
        int hi, lo, s;
        hi = sgn ? (1 << (AW - 1)) - 1 : (1 << AW) - 1;
        lo = sgn ? -(1 << (AW - 1)) : 0;
        s  = acc + x * y;
        ov = s > hi || s < lo;
        if (!ov) return s;
        if (sat) return s > hi ? hi : lo;
        s = ((s % (1 << AW)) + (1 << AW)) % (1 << AW);
        return val(s, AW, sgn);
    endfunction

    function automatic int obs(int i);
        return m_sgn[i] ? int'($signed(acc_o[i])) : int'(acc_o[i]);
    endfunction

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_acc%0d", tag, i), obs(i), m_acc[i]);
            check($sformatf("%s_ovf%0d", tag, i), int'(flg_o[i]), int'(m_ovf[i]));
        end
    endtask

    task automatic check_ctl(string tag, int rdy, int vld);
        check({tag, "_rdy"}, int'(rdy_o[0]), rdy);
        check({tag, "_busy"}, int'(busy_o[0]), rdy);
        check({tag, "_vld"}, int'(vld_o[0]), vld);
    endtask

    task automatic do_start(int init);
        start    = 1'b1;
        acc_init = AW'(init);
        in_valid = 1'($urandom_range(1));
        a        = DW'($urandom);
        b        = DW'($urandom);
        cyc();
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_acc[i] = val(init & ((1 << AW) - 1), AW, m_sgn[i]);
            m_ovf[i] = 1'b0;
        end
        m_cnt   = 0;
        one_act = 1'b1;
        check_all("start");
        check_ctl("start", 1, 0);
    endtask

    task automatic push(int x, int y, int gap);
        bit ov;
        repeat (gap) begin
            in_valid = 1'b0;
            a        = DW'($urandom);
            b        = DW'($urandom);
            cyc();
            check_all("gap");
            check_ctl("gap", 1, 0);
        end
        in_valid = 1'b1;
        a        = DW'(x);
        b        = DW'(y);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if (i < 3 || one_act) begin
                m_acc[i] = step(m_acc[i], val(x, DW, m_sgn[i]), val(y, DW, m_sgn[i]), m_sgn[i], m_sat[i], ov);
                m_ovf[i] = m_ovf[i] | ov;
            end
        end
        check("one_vld", int'(vld_o[3]), int'(one_act));
        one_act = 1'b0;
        m_cnt++;
        check_all("acc");
        check_ctl("acc", int'(m_cnt != LEN), int'(m_cnt == LEN));
    endtask

    task automatic go_idle();
        in_valid = 1'($urandom_range(1));
        a        = DW'($urandom);
        b        = DW'($urandom);
        cyc();
        in_valid = 1'b0;
        check_all("idle");
        check_ctl("idle", 0, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        acc_init = '0;
        a        = '0;
        b        = '0;
        m_cnt    = 0;
        one_act  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        check_all("rst");
        check_ctl("rst", 0, 0);

        do_start(0);
        repeat (4) push(2, 2, 0);
        check("t2_final", int'(acc_o[0]), 16);
        go_idle();
        check("t2_hold", int'(acc_o[0]), 16);

        do_start(0);
        push(2, 2, 0);
        push(3, 3, $urandom_range(1, 3));
        push(1, 1, $urandom_range(1, 3));
        push(1, 1, $urandom_range(1, 3));
        check("t3_final", int'(acc_o[0]), 15);
        go_idle();

        do_start(250);
        push(3, 3, 0);
        check("t4_sat_first", int'(acc_o[0]), 255);
        check("t4_wrap_first", int'(acc_o[1]), 3);
        push(1, 1, 0);
        push(0, 0, 0);
        push(0, 0, 0);
        check("t4_sat_final", int'(acc_o[0]), 255);
        check("t4_wrap_final", int'(acc_o[1]), 4);
        check("t4_wrap_ovf", int'(flg_o[1]), 1);
        go_idle();

        do_start(0);
        push(3, 1, 0);
        push(2, 1, 0);
        push(1, 1, 0);
        push(2, 2, 0);
        check("t5_signed", int'($signed(acc_o[2])), 2);
        check("t5_ovf", int'(flg_o[2]), 0);
        go_idle();

        do_start(0);
        push($urandom_range(3), $urandom_range(3), 0);
        push($urandom_range(3), $urandom_range(3), 0);
        do_start(5);
        repeat (4) push(1, 1, 0);
        check("t6_abort", int'(acc_o[0]), 9);
        do_start($urandom_range(255));
        repeat (3) push($urandom_range(3), $urandom_range(3), $urandom_range(1));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_cnt   = 0;
        one_act = 1'b0;
        check_all("midrst");
        check_ctl("midrst", 0, 0);
        cyc();
        check_ctl("postrst", 0, 0);

        repeat (40) begin
            do_start($urandom_range(255));
            for (int k = 0; k < LEN; k++) begin
                if ($urandom_range(9) == 0) begin
                    do_start($urandom_range(255));
                    k = -1;
                    continue;
                end
                push($urandom_range(3), $urandom_range(3), $urandom_range(2));
            end
            if ($urandom_range(1) == 1) go_idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
